fwd_hazard_unit: RTL

Operand-forwarding and load-use hazard controller for the 5-stage pipelined RV32I core. Tracks the destination registers of instructions in EX, MEM and WB in its own shadow pipeline. Drives the 2-bit select inputs of the two EX-stage operand 4:1 muxes (ALU operand A and B). Generates the one-cycle load-use stall and bubble for the IF/ID/EX registers.

---
 rtl/core_pkg.sv | 27 ++
 rtl/fwd_hazard_unit_if.sv | 35 +++
 rtl/fwd_hazard_unit_fwd_select.sv | 30 +++
 rtl/fwd_hazard_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32I pipeline hazard logic.
package core_pkg;

    localparam int REG_ADDR_W = 5;

    // EX-stage operand mux select encoding
    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_MEMWB   = 2'b01,
        FWD_EXMEM   = 2'b10,
        FWD_LINK    = 2'b11
    } fwd_sel_e;

    // One shadow-pipeline slot; MEM and WB only look at the rd-related fields
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  uses_rs1;
        logic                  uses_rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic                  link;
    } slot_t;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if: ID-stage decode info and pipeline control in,
// forwarding selects and stall out. The master side is the pipeline.
interface fwd_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  freeze;
    logic                  ex_flush;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  id_link;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  stall;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output freeze, ex_flush, id_valid, id_rs1, id_rs2, id_uses_rs1,
               id_uses_rs2, id_rd, id_regwrite, id_memread, id_link,
        input  fwd_a_sel, fwd_b_sel, stall, stall_count
    );

    modport slave (
        input  freeze, ex_flush, id_valid, id_rs1, id_rs2, id_uses_rs1,
               id_uses_rs2, id_rd, id_regwrite, id_memread, id_link,
        output fwd_a_sel, fwd_b_sel, stall, stall_count
    );

endinterface

// File: rtl/fwd_hazard_unit_fwd_select.sv
// fwd_select: operand forwarding select for one EX-stage source operand,
// derived purely from the registered EX/MEM/WB shadow slots.
module fwd_select
    import core_pkg::*;
(
    input  logic                  i_uses,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  slot_t                 i_mem,
    input  slot_t                 i_wb,
    output fwd_sel_e              o_sel
);

    logic w_src_live;
    logic w_mem_hit;
    logic w_wb_hit;

    // Newest producer wins (MEM before WB); x0 is never forwarded
    always_comb begin
        w_src_live = i_uses && (i_rs != '0);
        w_mem_hit  = w_src_live && i_mem.valid && i_mem.regwrite && (i_mem.rd == i_rs);
        w_wb_hit   = w_src_live && i_wb.valid && i_wb.regwrite && (i_wb.rd == i_rs);
        o_sel      = FWD_REGFILE;
        if (w_mem_hit) begin
            o_sel = i_mem.link ? FWD_LINK : FWD_EXMEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: shadow EX/MEM/WB tracking, load-use stall generation and
// EX operand forwarding selects for the 5-stage RV32I core.
module fwd_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fwd_hazard_unit_if.slave        bus
);

    import core_pkg::slot_t;
    import core_pkg::fwd_sel_e;

    slot_t            r_ex;
    slot_t            r_mem;
    slot_t            r_wb;
    slot_t            w_id_slot;
    logic             w_stall;
    logic             w_rs1_dep;
    logic             w_rs2_dep;
    fwd_sel_e         w_sel_a;
    fwd_sel_e         w_sel_b;
    logic [CNT_W-1:0] r_stall_count;

    // Pack the ID-stage decode fields into the slot image that enters EX
    always_comb begin
        w_id_slot          = '0;
        w_id_slot.valid    = bus.id_valid;
        w_id_slot.rs1      = bus.id_rs1;
        w_id_slot.rs2      = bus.id_rs2;
        w_id_slot.uses_rs1 = bus.id_uses_rs1;
        w_id_slot.uses_rs2 = bus.id_uses_rs2;
        w_id_slot.rd       = bus.id_rd;
        w_id_slot.regwrite = bus.id_regwrite;
        w_id_slot.memread  = bus.id_memread;
        w_id_slot.link     = bus.id_link;
    end

    // Load in EX feeding the ID instruction forces a one-cycle stall; a flush kills it
    always_comb begin
        w_rs1_dep = bus.id_uses_rs1 && (bus.id_rs1 == r_ex.rd);
        w_rs2_dep = bus.id_uses_rs2 && (bus.id_rs2 == r_ex.rd);
        w_stall   = bus.id_valid && r_ex.valid && r_ex.memread && r_ex.regwrite &&
                    (r_ex.rd != '0) && (w_rs1_dep || w_rs2_dep) && !bus.ex_flush;
    end

    // Advance the shadow pipeline unless frozen; flush or stall inserts a bubble into EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!bus.freeze) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (bus.ex_flush || w_stall) begin
                r_ex <= '0;
            end else begin
                r_ex <= w_id_slot;
            end
        end
    end

    // Saturating count of stall cycles that actually took effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (!bus.freeze && w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    fwd_select u_fwd_a (
        .i_uses (r_ex.uses_rs1),
        .i_rs   (r_ex.rs1),
        .i_mem  (r_mem),
        .i_wb   (r_wb),
        .o_sel  (w_sel_a)
    );

    fwd_select u_fwd_b (
        .i_uses (r_ex.uses_rs2),
        .i_rs   (r_ex.rs2),
        .i_mem  (r_mem),
        .i_wb   (r_wb),
        .o_sel  (w_sel_b)
    );

    assign bus.fwd_a_sel   = w_sel_a;
    assign bus.fwd_b_sel   = w_sel_b;
    assign bus.stall       = w_stall;
    assign bus.stall_count = r_stall_count;

endmodule
